// File: rtl/multi_dataflow_mul_mdc_job_sched_pkg.sv
// Shared types and constants for the multi_dataflow_mul_mdc job scheduler.
// Holds the FSM state encoding, the queued job entry layout and the default
// job queue depth. Job entry field widths are the widest lengths/configs the
// scheduler can queue; the top narrows or widens to its own LEN_W/CFG_W.
package multi_dataflow_mul_mdc_package;

  localparam int unsigned JOB_SCHED_DEFAULT_DEPTH = 4;
  localparam int unsigned JOB_SCHED_CORE_W        = 4;
  localparam int unsigned JOB_SCHED_LEN_W         = 16;
  localparam int unsigned JOB_SCHED_CFG_W         = 8;

  typedef logic [2:0] job_sched_state_t;

  localparam job_sched_state_t JS_IDLE  = 3'd0;
  localparam job_sched_state_t JS_CFG   = 3'd1;
  localparam job_sched_state_t JS_START = 3'd2;
  localparam job_sched_state_t JS_RUN   = 3'd3;
  localparam job_sched_state_t JS_DONE  = 3'd4;

  typedef struct packed {
    logic [JOB_SCHED_CORE_W-1:0] core_id;
    logic [JOB_SCHED_LEN_W-1:0]  len;
    logic [JOB_SCHED_CFG_W-1:0]  cfg;
  } job_entry_t;

endpackage

// File: rtl/multi_dataflow_mul_mdc_job_sched_job_fifo.sv
// Job queue for the scheduler: a DEPTH-entry FIFO of job_entry_t.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset (empties the queue)
//   clear_i        sync flush, wins over push/pop
//   push_i/data_i  enqueue (ignored when full)
//   pop_i/data_o   dequeue; data_o shows the head entry
//   full_o/empty_o occupancy flags
module multi_dataflow_mul_mdc_job_fifo
  import multi_dataflow_mul_mdc_package::*;
#(
  parameter int unsigned DEPTH = JOB_SCHED_DEFAULT_DEPTH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       push_i,
  input  job_entry_t data_i,
  input  logic       pop_i,
  output job_entry_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  job_entry_t       r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // Extra MSB on the pointers distinguishes full from empty.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign data_o  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage, no reset needed: contents are only read behind the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/multi_dataflow_mul_mdc_job_sched.sv
// Job scheduler sharing one multi_dataflow_mul_mdc HWPE between N_CORES cores.
// Round-robin arbitrates job requests into a queue, then runs each job through
// CFG -> START -> RUN (beat counting) -> DONE and signals the owning core.
// Optional feature macro: MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
//   adds a RUN stall watchdog that aborts a job after TIMEOUT_CYCLES beat-less
//   cycles and reports it on err_evt_o instead of evt_o.
// Ports:
//   clk_i, rst_ni, clear_i        clock, async active-low reset, sync flush
//   req_i/len_i/cfg_i/gnt_o       per-core job offload (gnt_o combinational)
//   cfg_valid_o/cfg_o/cfg_ready_i config handshake to the engine
//   start_o/len_o                 engine start pulse and active job length
//   beat_i                        output stream beat strobe
//   busy_o/evt_o/err_evt_o        status and per-core done/abort events
module multi_dataflow_mul_mdc_job_sched
  import multi_dataflow_mul_mdc_package::*;
#(
  parameter int unsigned N_CORES        = 2,
  parameter int unsigned QUEUE_DEPTH    = JOB_SCHED_DEFAULT_DEPTH,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned CFG_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [N_CORES-1:0]       req_i,
  input  logic [N_CORES*LEN_W-1:0] len_i,
  input  logic [N_CORES*CFG_W-1:0] cfg_i,
  output logic [N_CORES-1:0]       gnt_o,
  output logic                     cfg_valid_o,
  output logic [CFG_W-1:0]         cfg_o,
  input  logic                     cfg_ready_i,
  output logic                     start_o,
  output logic [LEN_W-1:0]         len_o,
  input  logic                     beat_i,
  output logic                     busy_o,
  output logic [N_CORES-1:0]       evt_o,
  output logic [N_CORES-1:0]       err_evt_o
);

  localparam int unsigned CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  // Arbiter
  logic [CORE_W-1:0]  r_rr_ptr;
  logic [CORE_W-1:0]  w_rr_nxt;
  logic [N_CORES-1:0] w_gnt;
  logic [CORE_W-1:0]  w_gnt_idx;
  logic [CORE_W:0]    w_idx;
  logic               w_found;
  logic               w_accept;

  // Queue
  job_entry_t         w_push_entry;
  job_entry_t         w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;

  // FSM
  job_sched_state_t   r_state;
  job_sched_state_t   w_state_nxt;
  logic [CORE_W-1:0]  r_core;
  logic [CORE_W-1:0]  w_core_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [CFG_W-1:0]   r_cfg;
  logic [CFG_W-1:0]   w_cfg_nxt;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_cnt_nxt;

`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [STALL_W-1:0] r_stall;
  logic [STALL_W-1:0] w_stall_nxt;
  logic               r_err;
  logic               w_err_nxt;
`else
  logic               w_unused_timeout;
  assign w_unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  // Round-robin search starting at r_rr_ptr; no grant while full or flushing.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    if (!w_fifo_full && !clear_i) begin
      for (int unsigned i = 0; i < N_CORES; i++) begin
        w_idx = {1'b0, r_rr_ptr} + (CORE_W+1)'(i);
        if (w_idx >= (CORE_W+1)'(N_CORES)) w_idx = w_idx - (CORE_W+1)'(N_CORES);
        if (!w_found && req_i[CORE_W'(w_idx)]) begin
          w_found   = 1'b1;
          w_gnt_idx = CORE_W'(w_idx);
        end
      end
      if (w_found) w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  assign gnt_o    = w_gnt;
  assign w_accept = |(req_i & w_gnt);
  assign w_rr_nxt = (w_gnt_idx == CORE_W'(N_CORES - 1)) ? '0 : w_gnt_idx + CORE_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= w_rr_nxt;
  end

  always_comb begin
    w_push_entry         = '0;
    w_push_entry.core_id = JOB_SCHED_CORE_W'(w_gnt_idx);
    w_push_entry.len     = JOB_SCHED_LEN_W'(len_i[w_gnt_idx*LEN_W +: LEN_W]);
    w_push_entry.cfg     = JOB_SCHED_CFG_W'(cfg_i[w_gnt_idx*CFG_W +: CFG_W]);
  end

  multi_dataflow_mul_mdc_job_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_job_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_accept),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // FSM state and job registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= JS_IDLE;
      r_core  <= '0;
      r_len   <= '0;
      r_cfg   <= '0;
      r_cnt   <= '0;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
      r_stall <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_core  <= w_core_nxt;
      r_len   <= w_len_nxt;
      r_cfg   <= w_cfg_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
      r_stall <= w_stall_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_core_nxt  = r_core;
    w_len_nxt   = r_len;
    w_cfg_nxt   = r_cfg;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
    w_stall_nxt = r_stall;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      JS_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_core_nxt  = CORE_W'(w_head.core_id);
          w_len_nxt   = LEN_W'(w_head.len);
          w_cfg_nxt   = CFG_W'(w_head.cfg);
          w_state_nxt = JS_CFG;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      JS_CFG: begin
        // Zero-length jobs complete without ever starting the engine.
        if (cfg_ready_i) w_state_nxt = (r_len == '0) ? JS_DONE : JS_START;
      end
      JS_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = JS_RUN;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
        w_stall_nxt = '0;
`endif
      end
      JS_RUN: begin
        if (beat_i) begin
          if (r_cnt == r_len - LEN_W'(1)) w_state_nxt = JS_DONE;
          else                            w_cnt_nxt   = r_cnt + LEN_W'(1);
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
          w_stall_nxt = '0;
        end else if (r_stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = JS_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_stall_nxt = r_stall + STALL_W'(1);
`endif
        end
      end
      JS_DONE: w_state_nxt = JS_IDLE;
      default: w_state_nxt = JS_IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = JS_IDLE;
      w_pop       = 1'b0;
    end
  end

  // Outputs decoded straight from registered state
  assign busy_o      = (r_state != JS_IDLE);
  assign cfg_valid_o = (r_state == JS_CFG);
  assign start_o     = (r_state == JS_START);
  assign cfg_o       = r_cfg;
  assign len_o       = r_len;

  always_comb begin
    evt_o     = '0;
    err_evt_o = '0;
`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
    if (r_state == JS_DONE) begin
      if (r_err) err_evt_o[r_core] = 1'b1;
      else       evt_o[r_core]     = 1'b1;
    end
`else
    if (r_state == JS_DONE) evt_o[r_core] = 1'b1;
`endif
  end

endmodule

// File: tb/tb_multi_dataflow_mul_mdc_job_sched.sv
// Directed bench for multi_dataflow_mul_mdc_job_sched (N_CORES=2, depth 4).
module tb_multi_dataflow_mul_mdc_job_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [1:0]  req;
  logic [15:0] len0, len1;
  logic [7:0]  cfg0, cfg1;
  logic [31:0] len_bus;
  logic [15:0] cfg_bus;
  logic [1:0]  gnt;
  logic        cfg_valid;
  logic [7:0]  cfg_o;
  logic        cfg_ready;
  logic        start;
  logic [15:0] len_o;
  logic        beat;
  logic        busy;
  logic [1:0]  evt;
  logic [1:0]  err_evt;

  int n_cmp  = 0;
  int n_fail = 0;

  assign len_bus = {len1, len0};
  assign cfg_bus = {cfg1, cfg0};

  always #5 clk = ~clk;

  multi_dataflow_mul_mdc_job_sched #(
    .N_CORES        (2),
    .QUEUE_DEPTH    (4),
    .LEN_W          (16),
    .CFG_W          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .req_i       (req),
    .len_i       (len_bus),
    .cfg_i       (cfg_bus),
    .gnt_o       (gnt),
    .cfg_valid_o (cfg_valid),
    .cfg_o       (cfg_o),
    .cfg_ready_i (cfg_ready),
    .start_o     (start),
    .len_o       (len_o),
    .beat_i      (beat),
    .busy_o      (busy),
    .evt_o       (evt),
    .err_evt_o   (err_evt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] fill_gnt [8];
    logic [1:0] exp_evt  [4];
    logic [7:0] exp_cfg  [4];
    logic [1:0] beat_pat [5];
    int         n_evt;
    int         n_cfg;
    logic       saw_start;

    fill_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    exp_evt  = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_cfg  = '{8'h21, 8'h12, 8'h23, 8'h14};
    beat_pat = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd1};

    // Reset
    rst_n = 1'b0; clear = 1'b0; req = '0; len0 = '0; len1 = '0;
    cfg0 = '0; cfg1 = '0; cfg_ready = 1'b0; beat = 1'b0;
    repeat (3) cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_evt", 32'(evt), 32'd0);
    check("rst_err_evt", 32'(err_evt), 32'd0);
    check("rst_len_o", 32'(len_o), 32'd0);
    check("rst_cfg_o", 32'(cfg_o), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Test 1: core0 len=4 cfg=3, ready delayed one cycle
    req = 2'b01; len0 = 16'd4; cfg0 = 8'd3;
    #1 check("t1_gnt", 32'(gnt), 32'h1);
    cyc();
    req = 2'b00;
    #1 check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    cyc();
    check("t1_cfg_valid", 32'(cfg_valid), 32'd1);
    check("t1_cfg_o", 32'(cfg_o), 32'd3);
    check("t1_len_o", 32'(len_o), 32'd4);
    check("t1_cfg_nostart", 32'(start), 32'd0);
    cyc();
    check("t1_cfg_hold_valid", 32'(cfg_valid), 32'd1);
    check("t1_cfg_hold_o", 32'(cfg_o), 32'd3);
    cfg_ready = 1'b1;
    cyc();
    cfg_ready = 1'b0;
    check("t1_start", 32'(start), 32'd1);
    check("t1_start_cfg_valid", 32'(cfg_valid), 32'd0);
    cyc();
    check("t1_start_pulse", 32'(start), 32'd0);
    check("t1_run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      beat = beat_pat[i][0];
      cyc();
      check($sformatf("t1_evt_%0d", i), 32'(evt), (i == 4) ? 32'h1 : 32'h0);
    end
    beat = 1'b0;
    cyc();
    check("t1_evt_clear", 32'(evt), 32'h0);
    check("t1_back_idle", 32'(busy), 32'd0);

    // Test 3: core1 len=0 skips START/RUN
    cfg_ready = 1'b1;
    req = 2'b10; len1 = 16'd0; cfg1 = 8'h55;
    #1 check("t3_gnt", 32'(gnt), 32'h2);
    cyc();
    req = 2'b00;
    check("t3_idle", 32'(busy), 32'd0);
    cyc();
    check("t3_cfg_valid", 32'(cfg_valid), 32'd1);
    check("t3_cfg_o", 32'(cfg_o), 32'h55);
    check("t3_len_o", 32'(len_o), 32'd0);
    cyc();
    check("t3_evt", 32'(evt), 32'h2);
    check("t3_nostart", 32'(start), 32'd0);
    cyc();
    check("t3_evt_clear", 32'(evt), 32'h0);
    check("t3_nostart2", 32'(start), 32'd0);
    check("t3_idle_after", 32'(busy), 32'd0);

    // Test 2: both cores request every cycle, queue fills
    len0 = 16'd1; len1 = 16'd2;
    for (int k = 0; k < 8; k++) begin
      req  = 2'b11;
      cfg0 = 8'h10 + 8'(k);
      cfg1 = 8'h20 + 8'(k);
      beat = (k >= 5);
      #1 check($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(fill_gnt[k]));
      if (k == 2) begin
        check("t2_job0_cfg", 32'(cfg_o), 32'h10);
        check("t2_job0_valid", 32'(cfg_valid), 32'd1);
      end
      if (k == 6) check("t2_job0_evt", 32'(evt), 32'h1);
      if (k == 7) check("t2_pop_idle", 32'(busy), 32'd0);
      cyc();
    end
    req = 2'b00;
    n_evt = 0;
    n_cfg = 0;
    for (int t = 0; t < 60 && n_evt < 4; t++) begin
      if (cfg_valid && n_cfg < 4) begin
        check($sformatf("t2_cfg_%0d", n_cfg), 32'(cfg_o), 32'(exp_cfg[n_cfg]));
        n_cfg++;
      end
      if (evt != 2'b00) begin
        check($sformatf("t2_evt_%0d", n_evt), 32'(evt), 32'(exp_evt[n_evt]));
        n_evt++;
      end
      cyc();
    end
    beat = 1'b0;
    check("t2_evt_count", 32'(n_evt), 32'd4);
    check("t2_cfg_count", 32'(n_cfg), 32'd4);
    check("t2_idle", 32'(busy), 32'd0);

    // Test 4: clear in RUN after 2 of 8 beats with 2 jobs queued
    req = 2'b01; len0 = 16'd8; cfg0 = 8'h40;
    #1 check("t4_gnt0", 32'(gnt), 32'h1);
    cyc();
    req = 2'b10; len1 = 16'd3;
    #1 check("t4_gnt1", 32'(gnt), 32'h2);
    cyc();
    req = 2'b01; len0 = 16'd5;
    #1 check("t4_gnt2", 32'(gnt), 32'h1);
    cyc();
    req = 2'b00;
    check("t4_start", 32'(start), 32'd1);
    cyc();
    beat = 1'b1;
    check("t4_run", 32'(busy), 32'd1);
    cyc();
    cyc();
    beat = 1'b0;
    clear = 1'b1;
    check("t4_pre_clear_busy", 32'(busy), 32'd1);
    cyc();
    clear = 1'b0;
    check("t4_clear_idle", 32'(busy), 32'd0);
    check("t4_clear_evt", 32'(evt), 32'h0);
    beat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("t4_flushed_busy_%0d", i), 32'(busy), 32'd0);
      check($sformatf("t4_flushed_evt_%0d", i), 32'({err_evt, evt}), 32'h0);
    end
    beat = 1'b0;

    // Test 5: cfg_ready held low for 5 cycles
    cfg_ready = 1'b0;
    req = 2'b10; len1 = 16'd2; cfg1 = 8'h77;
    #1 check("t5_gnt", 32'(gnt), 32'h2);
    cyc();
    req = 2'b00;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_valid_%0d", i), 32'(cfg_valid), 32'd1);
      check($sformatf("t5_cfg_%0d", i), 32'(cfg_o), 32'h77);
      check($sformatf("t5_nostart_%0d", i), 32'(start), 32'd0);
      cyc();
    end
    cfg_ready = 1'b1;
    check("t5_valid_at_ready", 32'(cfg_valid), 32'd1);
    cyc();
    cfg_ready = 1'b0;
    check("t5_start", 32'(start), 32'd1);
    cyc();
    check("t5_start_pulse", 32'(start), 32'd0);
    beat = 1'b1;
    cyc();
    cyc();
    beat = 1'b0;
    check("t5_evt", 32'(evt), 32'h2);
    check("t5_len_o", 32'(len_o), 32'd2);
    cyc();
    check("t5_idle", 32'(busy), 32'd0);

`ifdef MULTI_DATAFLOW_MUL_MDC_JOB_SCHED_TIMEOUT_EN
    // Test 6: no beats in RUN, watchdog aborts after 16 stalled cycles
    cfg_ready = 1'b1;
    req = 2'b01; len0 = 16'd3; cfg0 = 8'h66;
    #1 check("t6_gnt", 32'(gnt), 32'h1);
    cyc();
    req = 2'b00;
    cyc();
    cyc();
    check("t6_start", 32'(start), 32'd1);
    saw_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check($sformatf("t6_run_%0d", i), 32'({busy, err_evt, evt}), 32'h10);
    end
    cyc();
    check("t6_err_evt", 32'(err_evt), 32'h1);
    check("t6_no_evt", 32'(evt), 32'h0);
    cyc();
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_err_clear", 32'(err_evt), 32'h0);
`else
    saw_start = 1'b0;
    check("err_evt_tied", 32'(err_evt), 32'h0);
`endif
    check("final_no_start", 32'(saw_start | start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
